// File: rtl/tile_sequencer_if.sv
// Tile command / instruction bus for tile_sequencer.
// slave  : sequencer side (takes commands, produces instructions)
// master : host/decoder side (issues commands, consumes instructions)
interface tile_sequencer_if #(
  parameter int ROWS_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [14:0]       cmd_wt_base;
  logic [14:0]       cmd_inp_base;
  logic [ROWS_W-1:0] cmd_num_rows;
  logic [3:0]        cmd_out_base;
  logic              instr_stall;
  logic [63:0]       instr_out;
  logic              instr_valid;

  modport master (
    output cmd_valid, cmd_wt_base, cmd_inp_base, cmd_num_rows, cmd_out_base, instr_stall,
    input  cmd_ready, instr_out, instr_valid
  );

  modport slave (
    input  cmd_valid, cmd_wt_base, cmd_inp_base, cmd_num_rows, cmd_out_base, instr_stall,
    output cmd_ready, instr_out, instr_valid
  );
endinterface

// File: rtl/tile_sequencer.sv
// Systolic-array tile instruction sequencer: weight load, MAC burst,
// pipeline drain, output store, one 64-bit instruction per cycle.
// Optional macro TILE_SEQ_STALL_CNT_EN adds o_stall_cycles, a saturating
// count of stalled busy cycles, cleared on reset and command acceptance.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | waiting for a command, cmd_ready high
// LOAD_WT | issuing ARRAY_DIM SEND_WT at wt_base+i
// MAC     | issuing num_rows MAC at inp_base+i
// DRAIN   | issuing DRAIN_LAT NOP while the array drains
// STORE   | issuing ARRAY_DIM STORE_OUT at out_base+i (mod 16),
//         | then one empty cycle so done lines up after the last store
// FIN     | done pulse, instr_out zero
module tile_sequencer #(
  parameter int ARRAY_DIM = 4,
  parameter int DRAIN_LAT = 7,
  parameter int ROWS_W    = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_abort,
  tile_sequencer_if.slave bus,
  output logic o_busy,
  output logic o_done
`ifdef TILE_SEQ_STALL_CNT_EN
  ,
  output logic [15:0] o_stall_cycles
`endif
);

  localparam int W_A   = $clog2(ARRAY_DIM + 1);
  localparam int W_D   = $clog2(DRAIN_LAT + 1);
  localparam int W_AD  = (W_A > W_D) ? W_A : W_D;
  localparam int CNT_W = (W_AD > ROWS_W) ? W_AD : ROWS_W;

  localparam logic [4:0] OP_SEND_WT   = 5'b00010;
  localparam logic [4:0] OP_MAC       = 5'b00001;
  localparam logic [4:0] OP_NOP       = 5'b11111;
  localparam logic [4:0] OP_STORE_OUT = 5'b00011;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_WT = 3'd1,
    MAC     = 3'd2,
    DRAIN   = 3'd3,
    STORE   = 3'd4,
    FIN     = 3'd5
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_remain, w_remain_nxt;
  logic [14:0]       r_addr, w_addr_nxt;
  logic [63:0]       r_instr, w_instr_nxt;
  logic              r_valid;
  logic [14:0]       r_inp_base;
  logic [ROWS_W-1:0] r_num_rows;
  logic [3:0]        r_out_base;
  logic              w_load_cmd;
  logic              w_last;

  function automatic logic [63:0] f_instr(input logic [4:0] op, input logic [14:0] addr);
    return {op, 1'b0, addr, 43'd0};
  endfunction

  assign w_last = (r_remain == CNT_W'(1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state, next instruction word and counter updates
  always_comb begin
    w_state_nxt  = r_state;
    w_remain_nxt = r_remain;
    w_addr_nxt   = r_addr;
    w_instr_nxt  = 64'h0;
    w_load_cmd   = 1'b0;
    if (i_abort && (r_state != IDLE)) begin
      w_state_nxt  = IDLE;
      w_remain_nxt = '0;
      w_addr_nxt   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.cmd_valid) begin
            w_load_cmd   = 1'b1;
            w_state_nxt  = LOAD_WT;
            w_remain_nxt = CNT_W'(ARRAY_DIM);
            w_addr_nxt   = bus.cmd_wt_base;
          end
        end
        LOAD_WT: begin
          if (!bus.instr_stall) begin
            w_instr_nxt  = f_instr(OP_SEND_WT, r_addr);
            w_addr_nxt   = r_addr + 15'd1;
            w_remain_nxt = r_remain - CNT_W'(1);
            if (w_last) begin
              if (r_num_rows != '0) begin
                w_state_nxt  = MAC;
                w_remain_nxt = CNT_W'(r_num_rows);
                w_addr_nxt   = r_inp_base;
              end else begin
                w_state_nxt  = DRAIN;
                w_remain_nxt = CNT_W'(DRAIN_LAT);
                w_addr_nxt   = '0;
              end
            end
          end
        end
        MAC: begin
          if (!bus.instr_stall) begin
            w_instr_nxt  = f_instr(OP_MAC, r_addr);
            w_addr_nxt   = r_addr + 15'd1;
            w_remain_nxt = r_remain - CNT_W'(1);
            if (w_last) begin
              w_state_nxt  = DRAIN;
              w_remain_nxt = CNT_W'(DRAIN_LAT);
              w_addr_nxt   = '0;
            end
          end
        end
        DRAIN: begin
          if (!bus.instr_stall) begin
            w_instr_nxt  = f_instr(OP_NOP, 15'd0);
            w_remain_nxt = r_remain - CNT_W'(1);
            if (w_last) begin
              w_state_nxt  = STORE;
              w_remain_nxt = CNT_W'(ARRAY_DIM);
              w_addr_nxt   = {11'd0, r_out_base};
            end
          end
        end
        STORE: begin
          if (r_remain == '0) begin
            w_state_nxt = FIN;
          end else if (!bus.instr_stall) begin
            w_instr_nxt  = f_instr(OP_STORE_OUT, r_addr);
            w_addr_nxt   = {11'd0, r_addr[3:0] + 4'd1};
            w_remain_nxt = r_remain - CNT_W'(1);
          end
        end
        FIN: begin
          w_state_nxt  = IDLE;
          w_addr_nxt   = '0;
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  // Datapath registers: instruction output, counters, latched command
  always_ff @(posedge clk) begin
    if (rst) begin
      r_instr    <= 64'h0;
      r_valid    <= 1'b0;
      r_remain   <= '0;
      r_addr     <= '0;
      r_inp_base <= '0;
      r_num_rows <= '0;
      r_out_base <= '0;
    end else begin
      r_instr  <= w_instr_nxt;
      r_valid  <= (w_instr_nxt[63:59] != 5'd0);
      r_remain <= w_remain_nxt;
      r_addr   <= w_addr_nxt;
      if (w_load_cmd) begin
        r_inp_base <= bus.cmd_inp_base;
        r_num_rows <= bus.cmd_num_rows;
        r_out_base <= bus.cmd_out_base;
      end
    end
  end

`ifdef TILE_SEQ_STALL_CNT_EN
  logic [15:0] r_stall_cycles;

  // Saturating count of busy cycles lost to downstream stall
  always_ff @(posedge clk) begin
    if (rst || w_load_cmd)
      r_stall_cycles <= 16'h0;
    else if (o_busy && bus.instr_stall && !i_abort && (r_stall_cycles != 16'hFFFF))
      r_stall_cycles <= r_stall_cycles + 16'd1;
  end

  assign o_stall_cycles = r_stall_cycles;
`endif

  assign bus.instr_out   = r_instr;
  assign bus.instr_valid = r_valid;
  assign bus.cmd_ready   = (r_state == IDLE);
  assign o_busy          = (r_state != IDLE);
  assign o_done          = (r_state == FIN);

endmodule

// File: doc/tile_sequencer.md
Name: tile_sequencer

Overview:
Generates the 64-bit instruction stream for one systolic-array tile: weight load, MAC burst, pipeline drain, output store. It accepts one tile command per handshake and drives the instruction decoder's instruction input one instruction per cycle. Downstream stall support is included. This replaces hand-written per-tile instruction sequences from the host.

Parameters:
ARRAY_DIM, 4, array rows/cols; number of SEND_WT and STORE_OUT instructions per tile (1..16)
DRAIN_LAT, 7, NOP cycles between last MAC and first STORE_OUT (array fill/drain latency, >=1)
ROWS_W, 8, width of the input-row count

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
cmd_valid  in  1  tile command valid
cmd_ready  out  1  high only in IDLE; command accepted on cmd_valid & cmd_ready
cmd_wt_base  in  15  first weight-buffer address
cmd_inp_base  in  15  first input-buffer address
cmd_num_rows  in  ROWS_W  number of MAC instructions (input rows)
cmd_out_base  in  4  first output-buffer address
abort  in  1  synchronous abort of current tile
instr_stall  in  1  downstream cannot take an instruction this cycle
instr_out  out  64  instruction to decoder, registered
instr_valid  out  1  instr_out carries a nonzero opcode
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse on tile completion

Behaviour:
- Instruction format: [63:59] opcode, [58:43] address (15-bit address zero-extended to 16), [42:0] zero.
- Opcodes issued: SEND_WT 5'b00010, MAC 5'b00001, NOP 5'b11111, STORE_OUT 5'b00011. "No instruction" is 64'h0.
- Reset: state IDLE, instr_out=0, instr_valid=0, busy=0, done=0, cmd_ready=1, all counters 0.
- States: IDLE -> LOAD_WT -> MAC -> DRAIN -> STORE -> FIN -> IDLE.
- IDLE: cmd_ready=1. On acceptance at edge N, latch all cmd_* fields and enter LOAD_WT. The first SEND_WT is visible on instr_out after edge N+1.
- LOAD_WT: issue ARRAY_DIM SEND_WT instructions with addresses wt_base+0..ARRAY_DIM-1.
- MAC: issue num_rows MAC instructions with addresses inp_base+0..num_rows-1. If num_rows==0, skip MAC and go straight from LOAD_WT to DRAIN.
- DRAIN: issue DRAIN_LAT NOP instructions.
- STORE: issue ARRAY_DIM STORE_OUT instructions with addresses out_base+i, with the 4-bit field wrapping mod 16.
- FIN: instr_out=0, done=1 for exactly one cycle, then IDLE. No command is accepted in FIN.
- Address arithmetic is modulo 2^15; wt/inp addresses wrap 7FFF->0000 silently.
- One instruction per non-stalled cycle; no gaps between states.
- instr_stall=1 during a cycle: the next registered instr_out=64'h0 and instr_valid=0. All counters and state freeze, DRAIN count included. Issue resumes with the un-issued instruction on the edge after stall drops.
- instr_stall is ignored in IDLE and FIN.
- abort=1 in any non-IDLE state: next edge forces IDLE, instr_out=0, no done pulse. Abort has priority over stall. Abort in IDLE has no effect.
- rst has priority over abort, stall and cmd. Reset mid-tile discards the tile.
- Ignored-input rule: cmd_* fields are ignored while busy; a later change of cmd_* does not affect a running tile.

Optional Feature:
TILE_SEQ_STALL_CNT_EN
- Defined: adds output stall_cycles[15:0]. It counts cycles with busy & instr_stall & ~abort, saturates at FFFF, and clears on rst and on each command acceptance.
- Undefined: the port and counter do not exist; behaviour is otherwise identical.

Test Plan:
1. ARRAY_DIM=4, DRAIN_LAT=7; cmd wt_base=0x10, inp_base=0x20, num_rows=3, out_base=2 -> 4 SEND_WT (0x10-0x13), 3 MAC (0x20-0x22), 7 NOP, 4 STORE_OUT (2-5) on 18 consecutive cycles; done pulses on cycle 19; cmd_ready returns to 1 on cycle 20.
2. num_rows=0 -> 4 SEND_WT then 7 NOP directly, no MAC opcodes, done after 15 instructions.
3. wt_base=0x7FFE, out_base=14 -> SEND_WT addresses 7FFE, 7FFF, 0000, 0001; STORE_OUT addresses 14, 15, 0, 1.
4. Stall for 3 cycles during the 2nd MAC -> 3 cycles of instr_out=0/instr_valid=0, then the 2nd MAC resumes, no instruction skipped or duplicated, done delayed by exactly 3 cycles; with TILE_SEQ_STALL_CNT_EN, stall_cycles=3.
5. abort during DRAIN with stall also high -> IDLE next cycle, instr_out=0, no done pulse; a new command is accepted on the following cycle.
6. rst asserted mid-STORE -> all outputs at reset values next cycle; cmd_valid held through reset is accepted the first cycle after rst drops.
